a2_lane_buf: RTL and testbench

Parametrised multi-channel successor to the single-bit `a2` pass-through. It carries `CHANNELS` independent lanes of `WIDTH`-bit data. Each lane has a valid/ready handshake and a `DEPTH`-entry elastic buffer. It sits between a producer and consumer whose back-pressure must not propagate combinationally. Each lane also provides per-lane flush and an occupancy report.

---
 rtl/a2_pkg.sv | 15 +
 rtl/a2_lane.sv | 77 +++++++
 rtl/a2_lane_buf.sv | 43 ++++
 tb/tb_a2_lane_buf.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/a2_pkg.sv
// Shared defaults and helpers for the a2 lane buffer family.
// No logic; constants and a constant function only.
// Not applicable.
package a2_pkg;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 4;

  // Width needed to hold an occupancy value 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/a2_lane.sv
// One elastic lane: DEPTH-entry circular buffer with valid/ready on both sides.
// Latency: a word accepted at edge t is presented on the output in cycle t+1.
// Backpressure: o_in_ready depends only on count, reset and flush; no path from i_out_ready.
module a2_lane
  import a2_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int CNT_W = level_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [CNT_W-1:0] o_level
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;

  // Handshake qualifiers and explicit pointer wrap (DEPTH need not be a power of two).
  always_comb begin
    o_in_ready   = rst_n && !i_flush && (r_count < CNT_FULL);
    o_out_valid  = (r_count != '0);
    w_push       = i_in_valid && o_in_ready;
    w_pop        = o_out_valid && i_out_ready;
    w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
    w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
    o_out_data   = o_out_valid ? r_mem[r_rd_ptr] : '0;
    o_level      = r_count;
  end

  // Storage is never reset; the output mask hides stale entries while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_in_data;
    end
  end

  // Pointers and count; flush takes priority over any same-cycle pop.
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/a2_lane_buf.sv
// CHANNELS independent elastic lanes, each a WIDTH x DEPTH buffer with flush and level.
// Latency: one cycle from accepted push to out_valid on the same lane.
// Backpressure: in_ready is registered-state only; consumer stalls never reach the producer combinationally.
module a2_lane_buf
  import a2_pkg::*;
#(
  parameter  int CHANNELS = DEF_CHANNELS,
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  localparam int CNT_W    = level_w(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  input  logic [CHANNELS-1:0]       flush,
  output logic [CHANNELS*CNT_W-1:0] level
);

  // Lanes share nothing but clock and reset; the top is pure slicing.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    a2_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_flush     (flush[c]),
      .i_in_valid  (in_valid[c]),
      .o_in_ready  (in_ready[c]),
      .i_in_data   (in_data[c*WIDTH +: WIDTH]),
      .o_out_valid (out_valid[c]),
      .i_out_ready (out_ready[c]),
      .o_out_data  (out_data[c*WIDTH +: WIDTH]),
      .o_level     (level[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_a2_lane_buf.sv
// Directed and scoreboarded checks of a2_lane_buf at CHANNELS=4, WIDTH=8, DEPTH=4.
// Inputs change 1ns after the rising edge; outputs are sampled mid-cycle.
// Back-pressure independence is probed by toggling out_ready within a cycle.
module tb_a2_lane_buf;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 3;

  logic            clk;
  logic            rst_n;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   out_valid;
  logic [CH-1:0]   out_ready;
  logic [CH*W-1:0] out_data;
  logic [CH-1:0]   flush;
  logic [CH*CW-1:0] level;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] sb [CH][$];

  a2_lane_buf #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] dat(input int c);
    return out_data[c*W +: W];
  endfunction

  function automatic logic [CW-1:0] lvl(input int c);
    return level[c*CW +: CW];
  endfunction

  task automatic push1(input int c, input logic [W-1:0] v);
    in_valid[c]       = 1'b1;
    in_data[c*W +: W] = v;
    step();
    in_valid[c]       = 1'b0;
  endtask

  task automatic pop1(input int c);
    out_ready[c] = 1'b1;
    step();
    out_ready[c] = 1'b0;
  endtask

  logic [CH-1:0] rdy_snap;
  logic [CH-1:0] acc;

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = '0;
    flush     = '0;
    step();
    step();

    // Reset state
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_ready_low", 32'(in_ready), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", 32'(in_ready), 32'hF);

    // Single push on lane 0
    push1(0, 8'hA5);
    chk("t1_out_valid", 32'(out_valid), 32'h1);
    chk("t1_data0", 32'(dat(0)), 32'hA5);
    chk("t1_level0", 32'(lvl(0)), 32'd1);
    pop1(0);
    chk("t1_empty_valid", 32'(out_valid), 32'h0);
    chk("t1_empty_data", out_data, 32'h0);

    // Fill to DEPTH, reject fifth, drain in order
    for (int i = 1; i <= D; i++) push1(0, 8'(i));
    chk("t2_level_full", 32'(lvl(0)), 32'd4);
    chk("t2_ready_full", 32'(in_ready[0]), 32'h0);
    in_valid[0] = 1'b1;
    in_data[7:0] = 8'h05;
    out_ready[0] = 1'b1;
    #1;
    chk("t2_full_ready_with_pop", 32'(in_ready[0]), 32'h0);
    out_ready[0] = 1'b0;
    step();
    in_valid[0] = 1'b0;
    chk("t2_fifth_rejected", 32'(lvl(0)), 32'd4);
    for (int i = 1; i <= D; i++) begin
      chk("t2_drain_data", 32'(dat(0)), 32'(i));
      pop1(0);
    end
    chk("t2_drained_level", 32'(lvl(0)), 32'd0);
    chk("t2_drained_data", 32'(dat(0)), 32'h0);

    // Streaming at level 2 on lane 2 across many pointer wraps
    push1(2, 8'h10);
    push1(2, 8'h11);
    for (int k = 0; k < 20; k++) begin
      in_valid[2]   = 1'b1;
      in_data[23:16] = 8'(8'h12 + k);
      out_ready[2]  = 1'b1;
      #1;
      chk("t3_stream_data", 32'(dat(2)), 32'(8'h10 + k));
      chk("t3_stream_level", 32'(lvl(2)), 32'd2);
      chk("t3_stream_ready", 32'(in_ready[2]), 32'h1);
      @(posedge clk);
      #1;
    end
    in_valid[2]  = 1'b0;
    out_ready[2] = 1'b0;
    chk("t3_tail0", 32'(dat(2)), 32'h24);
    pop1(2);
    chk("t3_tail1", 32'(dat(2)), 32'h25);
    pop1(2);
    chk("t3_empty", 32'(out_valid[2]), 32'h0);

    // Flush lane 1 with simultaneous push and pop; lane 3 must be untouched
    push1(1, 8'h21);
    push1(1, 8'h22);
    push1(1, 8'h23);
    push1(3, 8'h3C);
    flush[1]       = 1'b1;
    in_valid[1]    = 1'b1;
    in_data[15:8]  = 8'h24;
    out_ready[1]   = 1'b1;
    #1;
    chk("t4_flush_ready", 32'(in_ready[1]), 32'h0);
    step();
    flush[1]     = 1'b0;
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b0;
    chk("t4_level1", 32'(lvl(1)), 32'd0);
    chk("t4_valid1", 32'(out_valid[1]), 32'h0);
    chk("t4_data1", 32'(dat(1)), 32'h0);
    chk("t4_level3", 32'(lvl(3)), 32'd1);
    chk("t4_data3", 32'(dat(3)), 32'h3C);
    push1(1, 8'h25);
    chk("t4_after_flush_data", 32'(dat(1)), 32'h25);
    chk("t4_after_flush_level", 32'(lvl(1)), 32'd1);
    out_ready = 4'b1010;
    step();
    out_ready = '0;
    chk("t4_cleanup", 32'(level), 32'h0);

    // Mid-operation reset with all lanes at level 3
    in_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      in_data = {4{8'(8'h50 + i)}};
      step();
    end
    in_valid = '0;
    chk("t5_level_pre", 32'(level), {20'h0, 3'd3, 3'd3, 3'd3, 3'd3});
    rst_n = 1'b0;
    #1;
    chk("t5_ready_low", 32'(in_ready), 32'h0);
    step();
    chk("t5_level", 32'(level), 32'h0);
    chk("t5_out_valid", 32'(out_valid), 32'h0);
    chk("t5_out_data", out_data, 32'h0);
    chk("t5_ready_still_low", 32'(in_ready), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("t5_ready_release", 32'(in_ready), 32'hF);
    push1(0, 8'h77);
    chk("t5_first_push", 32'(dat(0)), 32'h77);
    pop1(0);

    // Randomised traffic on all lanes against a per-lane scoreboard
    for (int cyc = 0; cyc < 310; cyc++) begin
      for (int c = 0; c < CH; c++) begin
        if (cyc < 300 && !in_valid[c] && ($urandom_range(0, 1) == 1)) begin
          in_valid[c]       = 1'b1;
          in_data[c*W +: W] = 8'($urandom);
        end
      end
      out_ready = (cyc < 300) ? 4'($urandom) : 4'hF;
      #1;
      rdy_snap  = in_ready;
      out_ready = ~out_ready;
      #1;
      chk("rnd_ready_indep", 32'(in_ready), 32'(rdy_snap));
      out_ready = ~out_ready;
      #1;
      acc = '0;
      for (int c = 0; c < CH; c++) begin
        chk("rnd_level", 32'(lvl(c)), 32'(sb[c].size()));
        chk("rnd_valid", 32'(out_valid[c]), 32'(sb[c].size() != 0));
        if (out_valid[c] && out_ready[c]) begin
          if (sb[c].size() == 0) begin
            chk("rnd_underflow", 32'h1, 32'h0);
          end else begin
            chk("rnd_data", 32'(dat(c)), 32'(sb[c][0]));
            void'(sb[c].pop_front());
          end
        end
        if (in_valid[c] && in_ready[c]) begin
          sb[c].push_back(in_data[c*W +: W]);
          acc[c] = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      in_valid = in_valid & ~acc;
    end
    for (int c = 0; c < CH; c++) begin
      chk("rnd_final_sb", 32'(sb[c].size()), 32'h0);
      chk("rnd_final_level", 32'(lvl(c)), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
